// File: rtl/dm_bytelane_if.sv
// Data-memory access bundle between the MEM stage (master) and dm_bytelane (slave).
//   addr       byte address, word index = addr[ADDR_W-1:2]
//   wdata      store data, right-aligned
//   we         store request this cycle
//   store_type 0=SW 1=SH 2=SB 3=reserved
//   load_type  0=LW 1=LH 2=LHU 3=LB 4=LBU 5-7 reserved
//   rdata      combinational load result
//   err        combinational access error
//   busy       clear sweep in progress
interface dm_bytelane_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              we;
  logic [1:0]        store_type;
  logic [2:0]        load_type;
  logic [31:0]       rdata;
  logic              err;
  logic              busy;

  modport master (
    output addr, wdata, we, store_type, load_type,
    input  rdata, err, busy
  );

  modport slave (
    input  addr, wdata, we, store_type, load_type,
    output rdata, err, busy
  );
endinterface

// File: rtl/dm_bytelane.sv
// Byte-lane data memory for the MEM stage: word/half/byte stores through per-lane
// write enables, sign/zero-extended sub-word loads, alignment/range error flag,
// and a one-word-per-cycle clear sweep after reset.
//   clk_i    system clock
//   reset_i  synchronous active-high reset; starts/restarts the clear sweep
//   bus      dm_bytelane_if slave modport (addr/wdata/we/types in, rdata/err/busy out)
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_CLEAR | sweeping mem[cnt] <= 0, one word per edge; busy = 1
//   S_IDLE  | normal load/store service; busy = 0
module dm_bytelane #(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 14
) (
  input  logic          clk_i,
  input  logic          reset_i,
  dm_bytelane_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [31:0]        mem_q [DEPTH];

  logic [IDX_W-1:0]   widx;
  logic               in_range;
  logic [CNT_W-1:0]   idx_safe;
  logic [31:0]        rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic               ld_bad, st_bad, err_raw;
  logic [31:0]        rdata_d;

  logic [3:0]         wr_be;
  logic [CNT_W-1:0]   wr_idx;
  logic [31:0]        wr_data;

  assign widx     = bus.addr[ADDR_W-1:2];
  assign in_range = 32'(widx) < 32'(DEPTH);
  // Out-of-range addresses never reach the array; they read word 0 and are masked.
  assign idx_safe = in_range ? widx[CNT_W-1:0] : '0;
  assign rd_word  = mem_q[idx_safe];
  assign rd_half  = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (bus.addr[1:0])
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  // Load-side checks always apply; store-side checks only with we.
  always_comb begin
    ld_bad = !in_range;
    case (bus.load_type)
      3'd0:       if (bus.addr[1:0] != 2'b00) ld_bad = 1'b1;
      3'd1, 3'd2: if (bus.addr[0])            ld_bad = 1'b1;
      default: ;
    endcase
    st_bad = 1'b0;
    if (bus.we) begin
      case (bus.store_type)
        2'd0: st_bad = (bus.addr[1:0] != 2'b00);
        2'd1: st_bad = bus.addr[0];
        2'd2: st_bad = 1'b0;
        default: st_bad = 1'b1;
      endcase
    end
    err_raw = ld_bad || st_bad;
  end

  always_comb begin
    rdata_d = '0;
    if (!busy_q && !err_raw) begin
      case (bus.load_type)
        3'd0: rdata_d = rd_word;
        3'd1: rdata_d = {{16{rd_half[15]}}, rd_half};
        3'd2: rdata_d = {16'h0000, rd_half};
        3'd3: rdata_d = {{24{rd_byte[7]}}, rd_byte};
        3'd4: rdata_d = {24'h000000, rd_byte};
        default: rdata_d = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_d;
  assign bus.err   = !busy_q && err_raw;
  assign bus.busy  = busy_q;

  // Single write port shared by the sweep and normal stores; reset edges never write.
  always_comb begin
    wr_be   = 4'b0000;
    wr_idx  = '0;
    wr_data = '0;
    if (!reset_i) begin
      if (state_q == S_CLEAR) begin
        wr_be   = 4'b1111;
        wr_idx  = cnt_q;
        wr_data = '0;
      end else if (!busy_q && bus.we && !err_raw) begin
        wr_idx = idx_safe;
        case (bus.store_type)
          2'd0: begin
            wr_be   = 4'b1111;
            wr_data = bus.wdata;
          end
          2'd1: begin
            wr_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.wdata[15:0]}};
          end
          2'd2: begin
            wr_be   = 4'b0001 << bus.addr[1:0];
            wr_data = {4{bus.wdata[7:0]}};
          end
          default: wr_be = 4'b0000;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_be[l]) mem_q[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase
    busy_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_dm_bytelane.sv
module tb_dm_bytelane;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 7;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [7:0] ref_mem [DEPTH*4];

  always #5 clk = ~clk;

  dm_bytelane_if #(.ADDR_W(ADDR_W)) bus ();

  dm_bytelane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] a, input logic w, input logic [1:0] st,
                       input logic [2:0] lt, input logic [31:0] wd);
    bus.addr = a; bus.we = w; bus.store_type = st; bus.load_type = lt; bus.wdata = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [6:0] a, input logic [1:0] st, input logic [31:0] wd);
    drive(a, 1'b1, st, 3'd4, wd);
    tick();
    drive(a, 1'b0, 2'd0, 3'd4, 32'h0);
  endtask

  task automatic load_chk(input string tag, input logic [6:0] a, input logic [2:0] lt,
                          input logic [31:0] exp);
    drive(a, 1'b0, 2'd0, lt, 32'h0);
    chk(tag, bus.rdata, exp);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  function automatic logic model_err(input logic [6:0] a, input logic w,
                                     input logic [1:0] st, input logic [2:0] lt);
    logic e;
    e = (a[6:2] >= DEPTH);
    if (lt == 3'd0 && a[1:0] != 2'b00) e = 1'b1;
    if ((lt == 3'd1 || lt == 3'd2) && a[0]) e = 1'b1;
    if (w) begin
      if (st == 2'd0 && a[1:0] != 2'b00) e = 1'b1;
      if (st == 2'd1 && a[0]) e = 1'b1;
      if (st == 2'd3) e = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [6:0] a, input logic w,
                                              input logic [1:0] st, input logic [2:0] lt);
    int base;
    logic [7:0]  b;
    logic [15:0] h;
    if (model_err(a, w, st, lt)) return 32'h0;
    base = int'(a[6:2]) * 4;
    b = ref_mem[base + int'(a[1:0])];
    h = {ref_mem[base + 2*int'(a[1]) + 1], ref_mem[base + 2*int'(a[1])]};
    case (lt)
      3'd0: return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
      3'd1: return {{16{h[15]}}, h};
      3'd2: return {16'h0, h};
      3'd3: return {{24{b[7]}}, b};
      3'd4: return {24'h0, b};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_store(input logic [6:0] a, input logic w, input logic [1:0] st,
                             input logic [2:0] lt, input logic [31:0] wd);
    int base;
    if (!w || model_err(a, w, st, lt)) return;
    base = int'(a[6:2]) * 4;
    case (st)
      2'd0: for (int k = 0; k < 4; k++) ref_mem[base+k] = wd[8*k +: 8];
      2'd1: begin
        ref_mem[base + 2*int'(a[1])]     = wd[7:0];
        ref_mem[base + 2*int'(a[1]) + 1] = wd[15:8];
      end
      2'd2: ref_mem[base + int'(a[1:0])] = wd[7:0];
      default: ;
    endcase
  endtask

  initial begin
    int n;
    logic [6:0]  ra;
    logic        rw;
    logic [1:0]  rst_t;
    logic [2:0]  rlt;
    logic [31:0] rwd;

    reset = 1'b1;
    drive(7'h22, 1'b1, 2'd0, 3'd1, 32'hFFFF_FFFF);
    tick();
    chk("reset_busy", {31'h0, bus.busy}, 32'h1);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_err", {31'h0, bus.err}, 32'h0);
    reset = 1'b0;
    drive(7'h00, 1'b0, 2'd0, 3'd0, 32'h0);
    count_busy(n);
    chk("init_sweep_len", n, 16);

    // Preload, then reset pulse with a store held on word 2 throughout the sweep.
    store(7'h14, 2'd0, 32'hDEAD_BEEF);
    load_chk("preload", 7'h14, 3'd0, 32'hDEAD_BEEF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(7'h08, 1'b1, 2'd0, 3'd0, 32'h1234_5678);
    chk("busy_rdata", bus.rdata, 32'h0);
    drive(7'h22, 1'b1, 2'd0, 3'd1, 32'h1234_5678);
    chk("busy_err", {31'h0, bus.err}, 32'h0);
    drive(7'h08, 1'b1, 2'd0, 3'd0, 32'h1234_5678);
    count_busy(n);
    chk("sweep_len", n, 16);
    load_chk("cleared_w5", 7'h14, 3'd0, 32'h0);
    load_chk("busy_sw_dropped", 7'h08, 3'd0, 32'h0);

    store(7'h10, 2'd0, 32'h1122_3344);
    store(7'h11, 2'd2, 32'h0000_00AA);
    store(7'h12, 2'd1, 32'h0000_BEEF);
    load_chk("lane_merge", 7'h10, 3'd0, 32'hBEEF_AA44);

    store(7'h20, 2'd0, 32'h80FF_7F01);
    load_chk("lb_23", 7'h23, 3'd3, 32'hFFFF_FF80);
    load_chk("lbu_23", 7'h23, 3'd4, 32'h0000_0080);
    load_chk("lh_22", 7'h22, 3'd1, 32'hFFFF_80FF);
    load_chk("lhu_22", 7'h22, 3'd2, 32'h0000_80FF);
    load_chk("lb_20", 7'h20, 3'd3, 32'h0000_0001);
    load_chk("lh_20", 7'h20, 3'd1, 32'h0000_7F01);

    drive(7'h22, 1'b1, 2'd0, 3'd4, 32'hFFFF_FFFF);
    chk("sw_misalign_err", {31'h0, bus.err}, 32'h1);
    tick();
    load_chk("sw_misalign_nowr", 7'h20, 3'd0, 32'h80FF_7F01);
    drive(7'h21, 1'b0, 2'd0, 3'd1, 32'h0);
    chk("lh_misalign_err", {31'h0, bus.err}, 32'h1);
    chk("lh_misalign_rdata", bus.rdata, 32'h0);
    drive(7'h40, 1'b1, 2'd2, 3'd4, 32'h0000_0055);
    chk("sb_range_err", {31'h0, bus.err}, 32'h1);
    tick();
    load_chk("sb_range_nowr", 7'h00, 3'd0, 32'h0);
    drive(7'h24, 1'b1, 2'd3, 3'd0, 32'h7777_7777);
    chk("st3_err", {31'h0, bus.err}, 32'h1);
    tick();
    load_chk("st3_nowr", 7'h24, 3'd0, 32'h0);

    drive(7'h30, 1'b1, 2'd0, 3'd0, 32'hCAFE_F00D);
    chk("rdw_old", bus.rdata, 32'h0);
    tick();
    chk("rdw_new", bus.rdata, 32'hCAFE_F00D);
    store(7'h3C, 2'd0, 32'h5A5A_5A5A);

    reset = 1'b1;
    drive(7'h00, 1'b0, 2'd0, 3'd0, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_busy", {31'h0, bus.busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy(n);
    chk("restart_len", n, 16);
    for (int w = 0; w < DEPTH; w++) begin
      ra = 7'(w * 4);
      load_chk($sformatf("zero_w%0d", w), ra, 3'd0, 32'h0);
    end

    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 10000; i++) begin
      ra    = 7'($urandom_range(0, 127));
      rw    = 1'($urandom_range(0, 1));
      rst_t = 2'($urandom_range(0, 3));
      rlt   = 3'($urandom_range(0, 7));
      rwd   = $urandom;
      drive(ra, rw, rst_t, rlt, rwd);
      chk($sformatf("rnd%0d_err", i), {31'h0, bus.err}, {31'h0, model_err(ra, rw, rst_t, rlt)});
      chk($sformatf("rnd%0d_rdata", i), bus.rdata, model_rdata(ra, rw, rst_t, rlt));
      model_store(ra, rw, rst_t, rlt, rwd);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/dm_bytelane.md
Name: dm_bytelane

Overview:
- Parametrised data memory for the pipelined CPU's MEM stage; successor to the word-only data memory.
- Adds byte/halfword stores via per-lane write enables.
- Adds sign/zero-extended sub-word loads and alignment/range error detection.
- Replaces the single-cycle reset clear with a deterministic sweep FSM that clears every word one per cycle and reports busy.

Parameters:
- DEPTH, 3072, number of 32-bit words (any value ≥2, need not be a power of two)
- ADDR_W, 14, byte-address width; must satisfy 2^(ADDR_W-2) ≥ DEPTH

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; starts/restarts the clear sweep
- addr  input  ADDR_W  byte address; word index = addr[ADDR_W-1:2]
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- we  input  1  store request this cycle
- store_type  input  2  0=SW, 1=SH, 2=SB, 3=reserved (treated as no store, err=1 when we=1)
- load_type  input  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU, 5–7 reserved (rdata=0)
- rdata  output  32  combinational load result, extended per load_type
- err  output  1  combinational: misaligned, out of range, or reserved type for the current access
- busy  output  1  registered; 1 while the clear sweep is in progress

Behaviour:
- States: CLEAR, IDLE.
- reset=1 at a clock edge: state←CLEAR, sweep counter cnt←0, busy←1; memory is not written on that edge.
- Reset applies from any state; mid-sweep reset restarts cnt at 0.
- CLEAR with reset=0: mem[cnt]←0, cnt←cnt+1.
  - At the edge that clears word DEPTH-1: state←IDLE, busy←0.
  - busy is therefore high for exactly DEPTH edges after reset deasserts.
- While busy=1:
  - we is ignored (no memory write).
  - rdata=0 and err=0 regardless of inputs.
- IDLE, store (we=1, err=0) at the edge:
  - SW writes all 4 lanes.
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SB writes lane addr[1:0] with wdata[7:0].
  - Lane 0 = bits [7:0] (little-endian).
  - Unwritten lanes are unchanged.
- Load is combinational from the current memory contents. Selected byte = lane addr[1:0]; selected half = lanes at addr[1].
  - LW: full word.
  - LH/LB: sign-extended.
  - LHU/LBU: zero-extended.
- Read-during-write, same address: rdata shows old contents until the edge, new contents after it.
- err=1 when busy=0 and any of the following holds:
  - word index ≥ DEPTH;
  - LW/SW with addr[1:0]≠0;
  - LH/LHU/SH with addr[0]≠0;
  - we=1 with store_type=3.
  - Load-side checks apply always; store-side checks apply only when we=1.
- When err=1:
  - No memory write occurs.
  - rdata=0.
- Counter width: ceil(log2(DEPTH)) bits.
- No memory access outside 0..DEPTH-1 ever occurs.
- Outputs after reset: busy=1, rdata=0, err=0.

Test Plan:
- Reset sweep (DEPTH=16 build):
  - Preload mem[5]=32'hDEADBEEF.
  - Pulse reset 1 cycle.
  - Required: busy=1 for exactly 16 edges after deassert, then 0.
  - LW addr 0x14 → 32'h0.
  - SW during busy is discarded (read back 0).
- Byte/half stores:
  - SW 0x10←32'h11223344.
  - SB 0x11←8'hAA.
  - SH 0x12←16'hBEEF.
  - Required: LW 0x10 → 32'hBEEFAA44.
- Sub-word loads on word 32'h80FF7F01 at 0x20:
  - LB 0x23 → 32'hFFFFFF80.
  - LBU 0x23 → 32'h00000080.
  - LH 0x22 → 32'hFFFF80FF.
  - LHU 0x22 → 32'h000080FF.
  - LB 0x20 → 32'h00000001.
- Errors:
  - SW to 0x22: err=1, memory unchanged.
  - LH 0x21: err=1, rdata=0.
  - SB with word index=DEPTH: err=1, no write.
  - store_type=3 with we=1: err=1.
- Reset mid-sweep:
  - Assert reset again at sweep cycle 7.
  - Required: busy stays high for 16 further edges after the second deassert.
  - All words read 0 afterwards.
- Random regression:
  - 10k random aligned/misaligned accesses vs. a byte-array reference model.
  - rdata and err match every cycle.
